fpmult_share_arb: RTL and testbench

Round-robin arbiter and sequencer that shares one fully pipelined, non-stalling single-precision FP multiplier (multiply, normalize and round stages ending in a 32-bit product plus 5-bit flags) among NREQ requesters. It accepts operand pairs over per-requester valid/ready handshakes and issues at most one multiply per cycle. It tracks each issued operation's requester ID through a latency-matched tag pipeline and returns every product tagged with the ID of the requester that issued it. It sits between the accelerator's operand sources and the multiplier datapath.

---
 rtl/fpmult_share_arb.sv | 152 +++++++++++++++
 tb/tb_fpmult_share_arb.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpmult_share_arb.sv
// Round-robin arbiter sharing one pipelined FP multiplier among NREQ requesters.
// Define FPMULT_ARB_OUTREG_EN to add one output register stage on the result path.
module fpmult_share_arb #(
  parameter  int NREQ = 4,
  parameter  int LAT  = 4,
  localparam int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [32*NREQ-1:0]   req_a,
  input  logic [32*NREQ-1:0]   req_b,
  output logic                 mul_go,
  output logic [31:0]          mul_a,
  output logic [31:0]          mul_b,
  input  logic [31:0]          mul_z,
  input  logic [4:0]           mul_flags,
  output logic                 res_valid,
  output logic [IDW-1:0]       res_id,
  output logic [31:0]          res_z,
  output logic [4:0]           res_flags,
  output logic                 busy
);

  localparam int CNTW = $clog2(LAT + 4);

  logic [IDW-1:0] rrPtr, grantId, issueId, idxSel;
  logic           grantVld, xfer;
  int             idx;

  // Scan from rrPtr upward, wrapping at NREQ (NREQ need not be a power of two).
  always_comb begin
    req_ready = '0;
    grantId   = '0;
    grantVld  = 1'b0;
    idx       = 0;
    idxSel    = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(rrPtr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      idxSel = idx[IDW-1:0];
      if (!grantVld && req_valid[idxSel]) begin
        grantVld = 1'b1;
        grantId  = idxSel;
      end
    end
    if (en && !rst && grantVld) req_ready[grantId] = 1'b1;
  end

  assign xfer = en && grantVld;

  always_ff @(posedge clk) begin
    if (rst) begin
      rrPtr   <= '0;
      mul_go  <= 1'b0;
      mul_a   <= '0;
      mul_b   <= '0;
      issueId <= '0;
    end else begin
      mul_go <= xfer;
      if (xfer) begin
        mul_a   <= req_a[grantId*32 +: 32];
        mul_b   <= req_b[grantId*32 +: 32];
        issueId <= grantId;
        rrPtr   <= (grantId == IDW'(NREQ - 1)) ? '0 : grantId + 1'b1;
      end
    end
  end

  // Tag pipeline: stage 0 is the issue register itself, stage LAT lines up with mul_z.
  logic [LAT:1]             tagV;
  logic [LAT:1][IDW-1:0]    tagId;
  logic [LAT:0]             vldPipe;
  logic [LAT:0][IDW-1:0]    idPipe;

  assign vldPipe = {tagV, mul_go};
  assign idPipe  = {tagId, issueId};

  always_ff @(posedge clk) begin
    if (rst) begin
      tagV  <= '0;
      tagId <= '0;
    end else begin
      tagV  <= vldPipe[LAT-1:0];
      tagId <= idPipe[LAT-1:0];
    end
  end

  logic           resV0;
  logic [IDW-1:0] resId0;
  logic [31:0]    resZ0;
  logic [4:0]     resF0;

  always_ff @(posedge clk) begin
    if (rst) begin
      resV0  <= 1'b0;
      resId0 <= '0;
      resZ0  <= '0;
      resF0  <= '0;
    end else begin
      resV0 <= vldPipe[LAT];
      if (vldPipe[LAT]) begin
        resId0 <= idPipe[LAT];
        resZ0  <= mul_z;
        resF0  <= mul_flags;
      end
    end
  end

`ifdef FPMULT_ARB_OUTREG_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      res_valid <= 1'b0;
      res_id    <= '0;
      res_z     <= '0;
      res_flags <= '0;
    end else begin
      res_valid <= resV0;
      if (resV0) begin
        res_id    <= resId0;
        res_z     <= resZ0;
        res_flags <= resF0;
      end
    end
  end
`else
  assign res_valid = resV0;
  assign res_id    = resId0;
  assign res_z     = resZ0;
  assign res_flags = resF0;
`endif

  // Counts ops from transfer until their result is on the outputs.
  logic [CNTW-1:0] inFlight;

  always_ff @(posedge clk) begin
    if (rst) begin
      inFlight <= '0;
    end else begin
      case ({xfer, res_valid})
        2'b10:   inFlight <= inFlight + 1'b1;
        2'b01:   inFlight <= inFlight - 1'b1;
        default: inFlight <= inFlight;
      endcase
    end
  end

  assign busy = (inFlight != '0);

endmodule

// File: tb/tb_fpmult_share_arb.sv
// Scoreboard bench for fpmult_share_arb: reference arbiter model plus stub multiplier.
module tb_fpmult_share_arb;
  localparam int NREQ = 4;
  localparam int LAT  = 4;
  localparam int IDW  = 2;
`ifdef FPMULT_ARB_OUTREG_EN
  localparam int RLAT = LAT + 3;
`else
  localparam int RLAT = LAT + 2;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en  = 1'b0;
  always #5 clk = ~clk;

  logic [NREQ-1:0]    reqV = '0;
  logic [NREQ-1:0]    req_ready;
  logic [31:0]        reqA [NREQ];
  logic [31:0]        reqB [NREQ];
  logic [32*NREQ-1:0] reqAFlat, reqBFlat;
  logic               mul_go;
  logic [31:0]        mul_a, mul_b, mul_z;
  logic [4:0]         mul_flags;
  logic               res_valid;
  logic [IDW-1:0]     res_id;
  logic [31:0]        res_z;
  logic [4:0]         res_flags;
  logic               busy;

  always_comb begin
    reqAFlat = '0;
    reqBFlat = '0;
    for (int i = 0; i < NREQ; i++) begin
      reqAFlat[32*i +: 32] = reqA[i];
      reqBFlat[32*i +: 32] = reqB[i];
    end
  end

  fpmult_share_arb #(.NREQ(NREQ), .LAT(LAT)) dut (
    .clk(clk), .rst(rst), .en(en),
    .req_valid(reqV), .req_ready(req_ready), .req_a(reqAFlat), .req_b(reqBFlat),
    .mul_go(mul_go), .mul_a(mul_a), .mul_b(mul_b), .mul_z(mul_z), .mul_flags(mul_flags),
    .res_valid(res_valid), .res_id(res_id), .res_z(res_z), .res_flags(res_flags),
    .busy(busy)
  );

  // Simple normal-number multiply (truncating); exact for the directed 1.5*2.0 case.
  function automatic logic [31:0] refMul(input logic [31:0] a, input logic [31:0] b);
    logic [47:0] p;
    logic [9:0]  e;
    logic [22:0] m;
    p = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
    e = {2'b0, a[30:23]} + {2'b0, b[30:23]} - 10'd127;
    if (p[47]) begin
      m = p[46:24];
      e = e + 10'd1;
    end else begin
      m = p[45:23];
    end
    return {a[31] ^ b[31], e[7:0], m};
  endfunction

  function automatic logic [4:0] refFlags(input logic [31:0] a, input logic [31:0] b);
    return a[4:0] ^ b[8:4];
  endfunction

  // Stub multiplier: LAT register stages, never stalls, never reset.
  logic [31:0] stZ [LAT];
  logic [4:0]  stF [LAT];
  always @(posedge clk) begin
    stZ[0] <= refMul(mul_a, mul_b);
    stF[0] <= refFlags(mul_a, mul_b);
    for (int i = 1; i < LAT; i++) begin
      stZ[i] <= stZ[i-1];
      stF[i] <= stF[i-1];
    end
  end
  assign mul_z     = stZ[LAT-1];
  assign mul_flags = stF[LAT-1];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          id;
    logic [31:0] z;
    logic [4:0]  f;
    int          cyc;
  } exp_t;
  exp_t sb[$];

  int nCmp = 0;
  int nFail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nCmp++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: every presented result must match the oldest outstanding op.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst && res_valid) begin
      if (sb.size() == 0) begin
        nCmp++;
        nFail++;
        $display("FAIL unexpected_res: got res_valid with id %0d, want no result (cycle %0d)", res_id, cyc);
      end else begin
        e = sb.pop_front();
        chk("res_id", 32'(res_id), e.id);
        chk("res_z", res_z, e.z);
        chk("res_flags", 32'(res_flags), 32'(e.f));
        chk("res_latency", cyc - e.cyc, RLAT);
      end
    end
  end

  // Reference arbiter state.
  int          modelPtr = 0;
  logic        prevGo = 1'b0;
  logic [31:0] prevA, prevB;
  bit          keepValid = 0;
  bit          randMode = 0;
  int          grantCnt [NREQ];
  int          gseq[$];
  int          lastGrantCyc = 0;
  int          lastResCyc = -100;
  int          lastResId = 0;
  logic [31:0] lastResZ = '0;
  logic        busyAtLast = 1'b0;
  logic        busyAfter = 1'b1;

  function automatic int modelGrant(input logic [NREQ-1:0] v, input logic e, input int p);
    if (!e) return -1;
    for (int k = 0; k < NREQ; k++)
      if (v[(p + k) % NREQ]) return (p + k) % NREQ;
    return -1;
  endfunction

  task automatic newData(input int i);
    reqA[i] = $urandom;
    reqB[i] = $urandom;
  endtask

  task automatic stepCycle();
    int g;
    logic [NREQ-1:0] expRdy;
    @(negedge clk);
    g = rst ? -1 : modelGrant(reqV, en, modelPtr);
    expRdy = '0;
    if (g >= 0) expRdy[g] = 1'b1;
    chk("req_ready", 32'(req_ready), 32'(expRdy));
    chk("mul_go", 32'(mul_go), 32'(prevGo));
    if (prevGo) begin
      chk("mul_a", mul_a, prevA);
      chk("mul_b", mul_b, prevB);
    end
    if (res_valid) begin
      lastResCyc = cyc;
      lastResId  = int'(res_id);
      lastResZ   = res_z;
      busyAtLast = busy;
    end else if (cyc == lastResCyc + 1) begin
      busyAfter = busy;
    end
    if (rst) begin
      sb.delete();
      modelPtr = 0;
      prevGo   = 1'b0;
    end else if (g >= 0) begin
      sb.push_back('{id: g, z: refMul(reqA[g], reqB[g]), f: refFlags(reqA[g], reqB[g]), cyc: cyc});
      modelPtr = (g + 1) % NREQ;
      prevGo   = 1'b1;
      prevA    = reqA[g];
      prevB    = reqB[g];
      grantCnt[g]++;
      gseq.push_back(g);
      lastGrantCyc = cyc;
    end else begin
      prevGo = 1'b0;
    end
    @(posedge clk);
    #1;
    if (g >= 0) begin
      if (keepValid) newData(g);
      else reqV[g] = 1'b0;
    end
    if (randMode) begin
      en = ($urandom_range(0, 7) != 0);
      for (int i = 0; i < NREQ; i++)
        if (!reqV[i] && $urandom_range(0, 2) == 0) begin
          reqV[i] = 1'b1;
          newData(i);
        end
    end
  endtask

  task automatic drain();
    int quiet = 0;
    int guard = 0;
    while (quiet < RLAT + 3 && guard < 200) begin
      stepCycle();
      quiet = (sb.size() == 0) ? quiet + 1 : 0;
      guard++;
    end
    chk("drain_empty", sb.size(), 0);
  endtask

  initial begin : stim
    int singleIssue;
    for (int i = 0; i < NREQ; i++) begin
      newData(i);
      grantCnt[i] = 0;
    end
    // Reset: all valid and enabled, still no grants.
    reqV = '1;
    en   = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    repeat (2) stepCycle();
    @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 0);
    chk("rst_mul_go", 32'(mul_go), 0);
    chk("rst_mul_a", mul_a, 0);
    chk("rst_mul_b", mul_b, 0);
    chk("rst_res_valid", 32'(res_valid), 0);
    chk("rst_res_id", 32'(res_id), 0);
    chk("rst_res_z", res_z, 0);
    chk("rst_res_flags", 32'(res_flags), 0);
    chk("rst_busy", 32'(busy), 0);
    @(posedge clk);
    #1;
    rst  = 1'b0;
    reqV = '0;
    repeat (3) stepCycle();

    // Single op from requester 2: 1.5 * 2.0.
    reqA[2] = 32'h3FC00000;
    reqB[2] = 32'h40000000;
    reqV[2] = 1'b1;
    keepValid = 0;
    lastResCyc = -100;
    stepCycle();
    singleIssue = lastGrantCyc;
    drain();
    chk("single_z", lastResZ, 32'h40400000);
    chk("single_id", lastResId, 2);
    chk("single_lat", lastResCyc - singleIssue, RLAT);

    // Fairness from reset: all four valid for 12 cycles.
    rst = 1'b1;
    stepCycle();
    rst = 1'b0;
    for (int i = 0; i < NREQ; i++) grantCnt[i] = 0;
    gseq.delete();
    reqV = '1;
    keepValid = 1;
    repeat (12) stepCycle();
    reqV = '0;
    for (int i = 0; i < NREQ; i++) chk("fair_count", grantCnt[i], 3);
    chk("fair_len", gseq.size(), 12);
    for (int k = 0; k < gseq.size(); k++) chk("fair_order", gseq[k], k % NREQ);
    drain();

    // Pointer skip: move pointer to 1, then only 0 and 3 valid.
    keepValid = 0;
    reqV[0] = 1'b1;
    stepCycle();
    gseq.delete();
    reqV[0] = 1'b1;
    reqV[3] = 1'b1;
    keepValid = 1;
    repeat (3) stepCycle();
    reqV = '0;
    chk("skip_len", gseq.size(), 3);
    if (gseq.size() == 3) begin
      chk("skip_g0", gseq[0], 3);
      chk("skip_g1", gseq[1], 0);
      chk("skip_g2", gseq[2], 3);
    end
    drain();

    // en gating with ops in flight.
    reqV = '1;
    keepValid = 1;
    repeat (3) stepCycle();
    en = 1'b0;
    stepCycle();
    repeat (4) begin
      stepCycle();
      chk("gate_mul_go", 32'(mul_go), 0);
    end
    reqV = '0;
    en = 1'b1;
    busyAfter = 1'b1;
    drain();
    chk("gate_busy_last", 32'(busyAtLast), 1);
    chk("gate_busy_after", 32'(busyAfter), 0);

    // Reset mid-flight: three ops, reset two cycles later.
    reqV[0] = 1'b1;
    keepValid = 1;
    repeat (3) stepCycle();
    reqV = '0;
    keepValid = 0;
    repeat (2) stepCycle();
    rst = 1'b1;
    stepCycle();
    rst = 1'b0;
    lastResCyc = -100;
    repeat (LAT + 6) begin
      chk("rst_mid_busy", 32'(busy), 0);
      stepCycle();
    end
    chk("rst_mid_nores", lastResCyc, -100);
    gseq.delete();
    reqV = '1;
    stepCycle();
    chk("rst_mid_ptr", (gseq.size() > 0) ? gseq[0] : -1, 0);
    repeat (3) stepCycle();
    drain();

    // Randomized traffic.
    randMode = 1;
    repeat (400) stepCycle();
    randMode = 0;
    en = 1'b1;
    reqV = '0;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
    $finish;
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: bench did not finish, want completion");
    $fatal(1);
  end

endmodule
